hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter NUM_SRC, default 2: number of source-register operands per instruction.
REQ-002 Parameter REG_AW, default 5: register-address width.
REQ-003 Parameter MC_LAT, default 4, legal range 2..64: number of cycles a multi-cycle EX operation occupies EX.
REQ-004 Ports (name, direction, width, meaning):
- clk, in, 1: single clock.
- rst, in, 1: synchronous, active-high reset.
- regwrite_mem, in, 1: MEM-stage instruction writes the register file.
- regwrite_wb, in, 1: WB-stage instruction writes the register file.
- rs_ex, in, NUM_SRC x REG_AW: EX-stage source addresses.
- rd_mem, in, REG_AW: MEM-stage destination.
- rd_wb, in, REG_AW: WB-stage destination.
- fw_ex, out, NUM_SRC x 2: per-source forward select.
- memtoreg_ex, in, 1: EX-stage instruction is a load.
- rd_ex, in, REG_AW: EX-stage destination.
- rs_id, in, NUM_SRC x REG_AW: ID-stage source addresses.
- mc_start_ex, in, 1: a multi-cycle operation is in EX in its first cycle.
- branch_taken_ex, in, 1: taken branch or jump resolved in EX.
- stall_if, stall_id, stall_ex, out, 1 each: hold the corresponding pipeline register.
- flush_id, flush_ex, out, 1 each: insert a bubble into the corresponding pipeline register.
- bubble_mem, out, 1: insert a bubble into EX/MEM.
- mc_busy, out, 1: registered; a multi-cycle operation is in progress.

Function
REQ-005 fw_ex[i] SHALL be 2'b10 when regwrite_mem and rd_mem==rs_ex[i]; otherwise 2'b01 when regwrite_wb and rd_wb==rs_ex[i]; otherwise 2'b00. It SHALL be forced to 2'b00 when rs_ex[i]==0. MEM SHALL win over WB. The path SHALL be combinational, with zero latency.
REQ-006 Load-use is detected when memtoreg_ex, rd_ex!=0, and rd_ex equals any rs_id[i]. On detection, stall_if, stall_id and flush_ex SHALL all be 1 for that cycle.
REQ-007 When branch_taken_ex is 1, flush_id and flush_ex SHALL be 1, and stall_if and stall_id SHALL be 0, in the same cycle.
REQ-008 If branch_taken_ex and a load-use hazard occur in the same cycle, the branch SHALL win: no stall is asserted, and the flushes follow REQ-007.
REQ-009 The FSM SHALL have two states, IDLE and MC_BUSY, and a counter of width $clog2(MC_LAT).
REQ-010 In IDLE with mc_start_ex=1, the FSM SHALL move to MC_BUSY on the next edge and load the counter with MC_LAT-2.
REQ-011 In the mc_start_ex cycle itself, stall_if, stall_id and stall_ex SHALL be 1, and bubble_mem SHALL be 1.
REQ-012 In MC_BUSY with counter>0, the counter SHALL decrement each cycle. stall_if, stall_id, stall_ex and bubble_mem SHALL all be 1.
REQ-013 In MC_BUSY with counter==0, the stall and bubble outputs SHALL be 0, and the FSM SHALL return to IDLE on the next edge. Total stall is MC_LAT-1 cycles, and the result leaves EX in cycle MC_LAT.
REQ-014 In MC_BUSY, branch_taken_ex, load-use and mc_start_ex SHALL be ignored. During the final cycle of REQ-013, load-use and branch SHALL be evaluated normally.
REQ-015 mc_busy SHALL equal (state==MC_BUSY).
REQ-016 Both flush_* and stall_* SHALL NOT be asserted on the same stage in the same cycle. For the same stage, flush SHALL take precedence.

Reset
REQ-017 While rst=1, the state SHALL be IDLE and the counter 0 at the next edge.
REQ-018 While rst=1, all stall_*, flush_* and bubble_mem outputs SHALL be 0, and fw_ex SHALL be all-zero.
REQ-019 Reset asserted in MC_BUSY SHALL abort the operation: IDLE on the next edge, with no residual stall after rst deasserts.

Structure
REQ-020 Package hazard_pkg SHALL hold:
- fw_sel_t enum: NO_FW=2'b00, FW_WB=2'b01, FW_MEM=2'b10.
- mc_state_t enum: IDLE, MC_BUSY.
REQ-021 Sub-module fw_select (one source: rs, rd_mem, rd_wb, regwrite_mem, regwrite_wb -> fw_sel_t) SHALL be instantiated NUM_SRC times via generate.

Verification
REQ-022 rs_ex={5,7}, rd_mem=5, regwrite_mem=1, rd_wb=7, regwrite_wb=1 -> fw_ex={10,01}. Change to rd_mem=rd_wb=5 -> fw_ex[0]=10. rs_ex[0]=0 with rd_mem=0 -> 00.
REQ-023 memtoreg_ex=1, rd_ex=3, rs_id={0,3} -> stall_if=stall_id=flush_ex=1 for one cycle. Repeat with rd_ex=0 -> no stall.
REQ-024 MC_LAT=4, mc_start_ex pulse at cycle T -> stall_ex and bubble_mem high in T..T+2 and low at T+3; mc_busy high in T+1..T+3. A branch_taken_ex pulse at T+1 is ignored.
REQ-025 Load-use and branch_taken_ex in the same cycle -> flush_id=flush_ex=1, stall_if=stall_id=0.
REQ-026 rst=1 at T+1 of a MC_LAT=8 operation -> outputs 0 during reset, IDLE after one edge, and no stall after rst falls.
REQ-027 NUM_SRC=3, REG_AW=6 build: a match on the third source produces a load-use stall, and REQ-022 holds per source.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forward-select codes and
// the multi-cycle EX occupancy states.
package hazard_pkg;

    typedef enum logic [1:0] {
        NO_FW  = 2'b00,
        FW_WB  = 2'b01,
        FW_MEM = 2'b10
    } fw_sel_t;

    typedef enum logic {
        IDLE    = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_t;

endpackage

// File: rtl/hazard_ctrl_fw_select.sv
// Forwarding mux select for a single EX source operand. The MEM stage holds
// the younger result, so it is checked before WB.
module fw_select
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rd_mem,
    input  logic [REG_AW-1:0] rd_wb,
    input  logic              regwrite_mem,
    input  logic              regwrite_wb,
    output fw_sel_t           sel
);

    always_comb begin
        sel = NO_FW;
        // r0 is hardwired to zero and is never forwarded
        if (rs != '0) begin
            if (regwrite_mem && (rd_mem == rs)) begin
                sel = FW_MEM;
            end else if (regwrite_wb && (rd_wb == rs)) begin
                sel = FW_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: EX operand forwarding, load-use stall, taken
// branch flush and multi-cycle EX occupancy sequencing.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int REG_AW  = 5,
    parameter int MC_LAT  = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            regwrite_mem,
    input  logic                            regwrite_wb,
    input  logic [NUM_SRC-1:0][REG_AW-1:0]  rs_ex,
    input  logic [REG_AW-1:0]               rd_mem,
    input  logic [REG_AW-1:0]               rd_wb,
    output logic [NUM_SRC-1:0][1:0]         fw_ex,
    input  logic                            memtoreg_ex,
    input  logic [REG_AW-1:0]               rd_ex,
    input  logic [NUM_SRC-1:0][REG_AW-1:0]  rs_id,
    input  logic                            mc_start_ex,
    input  logic                            branch_taken_ex,
    output logic                            stall_if,
    output logic                            stall_id,
    output logic                            stall_ex,
    output logic                            flush_id,
    output logic                            flush_ex,
    output logic                            bubble_mem,
    output logic                            mc_busy
);

    localparam int               CNT_W    = $clog2(MC_LAT);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_LAT - 2);

    mc_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    fw_sel_t          fw_sel [NUM_SRC];
    logic             load_use;
    logic             hz_eval;
    logic             st_if, st_id, st_ex, fl_id, fl_ex, bub;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_fw
        fw_select #(
            .REG_AW (REG_AW)
        ) u_fw_select (
            .rs           (rs_ex[gi]),
            .rd_mem       (rd_mem),
            .rd_wb        (rd_wb),
            .regwrite_mem (regwrite_mem),
            .regwrite_wb  (regwrite_wb),
            .sel          (fw_sel[gi])
        );
        assign fw_ex[gi] = rst ? 2'b00 : fw_sel[gi];
    end

    always_comb begin
        load_use = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (memtoreg_ex && (rd_ex != '0) && (rd_ex == rs_id[i])) begin
                load_use = 1'b1;
            end
        end
    end

    // Branch and load-use are only seen in IDLE or in the last busy cycle,
    // when the multi-cycle result is leaving EX.
    assign hz_eval = (state == IDLE) || (cnt == '0);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        st_if     = 1'b0;
        st_id     = 1'b0;
        st_ex     = 1'b0;
        fl_id     = 1'b0;
        fl_ex     = 1'b0;
        bub       = 1'b0;

        case (state)
            IDLE: begin
                if (mc_start_ex) begin
                    state_nxt = MC_BUSY;
                    cnt_nxt   = CNT_LOAD;
                    st_if     = 1'b1;
                    st_id     = 1'b1;
                    st_ex     = 1'b1;
                    bub       = 1'b1;
                end
            end
            MC_BUSY: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                    st_if   = 1'b1;
                    st_id   = 1'b1;
                    st_ex   = 1'b1;
                    bub     = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (hz_eval) begin
            if (branch_taken_ex) begin
                fl_id = 1'b1;
                fl_ex = 1'b1;
                st_if = 1'b0;
                st_id = 1'b0;
            end else if (load_use) begin
                st_if = 1'b1;
                st_id = 1'b1;
                fl_ex = 1'b1;
            end
        end

        // a flushed stage is never also held
        st_id = st_id & ~fl_id;
        st_ex = st_ex & ~fl_ex;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign stall_if   = st_if & ~rst;
    assign stall_id   = st_id & ~rst;
    assign stall_ex   = st_ex & ~rst;
    assign flush_id   = fl_id & ~rst;
    assign flush_ex   = fl_ex & ~rst;
    assign bubble_mem = bub   & ~rst;
    assign mc_busy    = (state == MC_BUSY);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: default build, an MC_LAT=8 build for reset
// abort, and a NUM_SRC=3 / REG_AW=6 build for the wide source case.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // shared controls
    logic rst = 1'b1, rst8 = 1'b1;
    logic regwrite_mem = 0, regwrite_wb = 0, memtoreg_ex = 0;
    logic mc_start_ex = 0, mc_start8 = 0, branch_taken_ex = 0;

    // default build
    logic [1:0][4:0] rs_ex, rs_id;
    logic [4:0]      rd_mem, rd_wb, rd_ex;
    logic [1:0][1:0] fw_ex;
    logic s_if, s_id, s_ex, f_id, f_ex, bub, busy;

    // MC_LAT=8 build
    logic [1:0][1:0] fw_ex8;
    logic s_if8, s_id8, s_ex8, f_id8, f_ex8, bub8, busy8;

    // NUM_SRC=3, REG_AW=6 build
    logic [2:0][5:0] rs_ex3, rs_id3;
    logic [5:0]      rd_mem3, rd_wb3, rd_ex3;
    logic [2:0][1:0] fw_ex3;
    logic s_if3, s_id3, s_ex3, f_id3, f_ex3, bub3, busy3;

    hazard_ctrl u_dut (
        .clk(clk), .rst(rst), .regwrite_mem(regwrite_mem), .regwrite_wb(regwrite_wb),
        .rs_ex(rs_ex), .rd_mem(rd_mem), .rd_wb(rd_wb), .fw_ex(fw_ex),
        .memtoreg_ex(memtoreg_ex), .rd_ex(rd_ex), .rs_id(rs_id),
        .mc_start_ex(mc_start_ex), .branch_taken_ex(branch_taken_ex),
        .stall_if(s_if), .stall_id(s_id), .stall_ex(s_ex),
        .flush_id(f_id), .flush_ex(f_ex), .bubble_mem(bub), .mc_busy(busy)
    );

    hazard_ctrl #(.MC_LAT(8)) u_dut8 (
        .clk(clk), .rst(rst8), .regwrite_mem(regwrite_mem), .regwrite_wb(regwrite_wb),
        .rs_ex(rs_ex), .rd_mem(rd_mem), .rd_wb(rd_wb), .fw_ex(fw_ex8),
        .memtoreg_ex(memtoreg_ex), .rd_ex(rd_ex), .rs_id(rs_id),
        .mc_start_ex(mc_start8), .branch_taken_ex(branch_taken_ex),
        .stall_if(s_if8), .stall_id(s_id8), .stall_ex(s_ex8),
        .flush_id(f_id8), .flush_ex(f_ex8), .bubble_mem(bub8), .mc_busy(busy8)
    );

    hazard_ctrl #(.NUM_SRC(3), .REG_AW(6)) u_dut3 (
        .clk(clk), .rst(rst), .regwrite_mem(regwrite_mem), .regwrite_wb(regwrite_wb),
        .rs_ex(rs_ex3), .rd_mem(rd_mem3), .rd_wb(rd_wb3), .fw_ex(fw_ex3),
        .memtoreg_ex(memtoreg_ex), .rd_ex(rd_ex3), .rs_id(rs_id3),
        .mc_start_ex(1'b0), .branch_taken_ex(1'b0),
        .stall_if(s_if3), .stall_id(s_id3), .stall_ex(s_ex3),
        .flush_id(f_id3), .flush_ex(f_ex3), .bubble_mem(bub3), .mc_busy(busy3)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // {stall_if, stall_id, stall_ex, flush_id, flush_ex, bubble_mem}
    function automatic logic [31:0] ctl();
        return 32'({s_if, s_id, s_ex, f_id, f_ex, bub});
    endfunction

    function automatic logic [31:0] ctl8();
        return 32'({s_if8, s_id8, s_ex8, f_id8, f_ex8, bub8});
    endfunction

    // advance one cycle, then leave a margin before driving
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rs_ex = '0; rs_id = '0; rd_mem = '0; rd_wb = '0; rd_ex = '0;
        rs_ex3 = '0; rs_id3 = '0; rd_mem3 = '0; rd_wb3 = '0; rd_ex3 = '0;

        // reset: hazards present at the inputs must not reach the outputs
        rs_ex[0] = 5'd5; rd_mem = 5'd5; regwrite_mem = 1'b1;
        memtoreg_ex = 1'b1; rd_ex = 5'd3; rs_id[1] = 5'd3; branch_taken_ex = 1'b1;
        step(); #1;
        chk("rst_ctl", ctl(), 32'h0);
        chk("rst_fw", 32'(fw_ex), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        memtoreg_ex = 0; branch_taken_ex = 0; regwrite_mem = 0;
        rs_ex = '0; rd_mem = '0; rd_ex = '0; rs_id = '0;
        rst = 1'b0; rst8 = 1'b0;
        step();

        // forwarding
        rs_ex[0] = 5'd5; rs_ex[1] = 5'd7; rd_mem = 5'd5; rd_wb = 5'd7;
        regwrite_mem = 1'b1; regwrite_wb = 1'b1; #1;
        chk("fw0_mem", 32'(fw_ex[0]), 32'h2);
        chk("fw1_wb", 32'(fw_ex[1]), 32'h1);
        rd_wb = 5'd5; #1;
        chk("fw0_mem_wins", 32'(fw_ex[0]), 32'h2);
        chk("fw1_none", 32'(fw_ex[1]), 32'h0);
        regwrite_mem = 1'b0; #1;
        chk("fw0_wb_only", 32'(fw_ex[0]), 32'h1);
        regwrite_mem = 1'b1; rs_ex[0] = 5'd0; rd_mem = 5'd0; rd_wb = 5'd0; #1;
        chk("fw0_r0", 32'(fw_ex[0]), 32'h0);
        regwrite_mem = 0; regwrite_wb = 0; rs_ex = '0;

        // load-use
        step();
        memtoreg_ex = 1'b1; rd_ex = 5'd3; rs_id[0] = 5'd0; rs_id[1] = 5'd3; #1;
        chk("lu_hit", ctl(), 32'b110010);
        step();
        chk("lu_one_cycle_busy", 32'(busy), 32'h0);
        rd_ex = 5'd0; rs_id[1] = 5'd0; #1;
        chk("lu_rd0", ctl(), 32'b000000);
        rd_ex = 5'd3; rs_id[0] = 5'd4; rs_id[1] = 5'd2; #1;
        chk("lu_nomatch", ctl(), 32'b000000);
        memtoreg_ex = 1'b0; rs_id[1] = 5'd3; #1;
        chk("lu_not_load", ctl(), 32'b000000);

        // branch alone, then branch colliding with load-use
        branch_taken_ex = 1'b1; #1;
        chk("br_only", ctl(), 32'b000110);
        memtoreg_ex = 1'b1; #1;
        chk("br_beats_lu", ctl(), 32'b000110);
        branch_taken_ex = 0; memtoreg_ex = 0; rd_ex = '0; rs_id = '0;

        // multi-cycle op, MC_LAT=4, start at T
        step();
        mc_start_ex = 1'b1; #1;
        chk("mc_T", ctl(), 32'b111001);
        chk("mc_T_busy", 32'(busy), 32'h0);
        step();                                   // T+1: branch and load-use ignored
        mc_start_ex = 1'b0; branch_taken_ex = 1'b1;
        memtoreg_ex = 1'b1; rd_ex = 5'd3; rs_id[1] = 5'd3; #1;
        chk("mc_T1", ctl(), 32'b111001);
        chk("mc_T1_busy", 32'(busy), 32'h1);
        step();
        branch_taken_ex = 0; memtoreg_ex = 0; #1;
        chk("mc_T2", ctl(), 32'b111001);
        chk("mc_T2_busy", 32'(busy), 32'h1);
        step();                                   // T+3: final cycle evaluates load-use
        memtoreg_ex = 1'b1; #1;
        chk("mc_T3_lu", ctl(), 32'b110010);
        chk("mc_T3_busy", 32'(busy), 32'h1);
        memtoreg_ex = 0; #1;
        chk("mc_T3", ctl(), 32'b000000);
        step(); #1;
        chk("mc_T4_busy", 32'(busy), 32'h0);
        chk("mc_T4", ctl(), 32'b000000);
        rd_ex = '0; rs_id = '0;

        // MC_LAT=8 aborted by reset at T+1
        mc_start8 = 1'b1; #1;
        chk("mc8_T", ctl8(), 32'b111001);
        step();
        mc_start8 = 1'b0; rst8 = 1'b1; #1;
        chk("mc8_rst_ctl", ctl8(), 32'h0);
        chk("mc8_rst_busy", 32'(busy8), 32'h1);
        step();
        rst8 = 1'b0; #1;
        chk("mc8_idle", 32'(busy8), 32'h0);
        chk("mc8_after_ctl", ctl8(), 32'h0);
        step(); #1;
        chk("mc8_after2_ctl", ctl8(), 32'h0);
        chk("mc8_after2_busy", 32'(busy8), 32'h0);

        // three-source build
        memtoreg_ex = 1'b1; rd_ex3 = 6'd9; rs_id3[2] = 6'd9; #1;
        chk("w_lu_src2", 32'({s_if3, s_id3, s_ex3, f_id3, f_ex3, bub3}), 32'b110010);
        rs_id3[2] = 6'd10; #1;
        chk("w_lu_none", 32'({s_if3, s_id3, f_ex3}), 32'b000);
        memtoreg_ex = 1'b0;
        regwrite_mem = 1'b1; regwrite_wb = 1'b1;
        rs_ex3[2] = 6'd40; rd_mem3 = 6'd40; rs_ex3[1] = 6'd33; rd_wb3 = 6'd33; rs_ex3[0] = 6'd0; #1;
        chk("w_fw", 32'(fw_ex3), 32'b10_01_00);
        rd_wb3 = 6'd40; #1;
        chk("w_fw_mem_wins", 32'(fw_ex3), 32'b10_00_00);
        regwrite_mem = 0; regwrite_wb = 0;

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
